// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/flush handshake bundle for the issue scoreboard.
// The master side is the pipeline; the slave side is the scoreboard.
interface issue_scoreboard_if #(parameter int NREG = 32);
    logic            dec_valid;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic [4:0]      dec_rd;
    logic            dec_wen;
    logic            issue_ready;
    logic            issue_fire;
    logic            stall;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            kill_valid;
    logic [4:0]      kill_rd;
    logic            busy;
    logic [NREG-1:0] pending_mask;
    logic            err;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_wen,
        output issue_ready, wb_valid, wb_rd, kill_valid, kill_rd,
        input  issue_fire, stall, busy, pending_mask, err
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_wen,
        input  issue_ready, wb_valid, wb_rd, kill_valid, kill_rd,
        output issue_fire, stall, busy, pending_mask, err
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Decode-stage issue scoreboard: per-register pending-write counters that
// stall decode on RAW hazards and on counter saturation.
module issue_scoreboard #(
    parameter int NREG = 32,
    parameter int CW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    issue_scoreboard_if.slave sb
);
    localparam int CMAX = (2 ** CW) - 1;

    logic [CW-1:0]   cnt_r      [NREG];
    logic [CW-1:0]   cnt_nxt_s  [NREG];
    logic [NREG-1:0] mask_r;
    logic [NREG-1:0] mask_nxt_s;
    logic            busy_r;
    logic            err_r;
    logic            under_s;
    logic            haz_s;
    logic            sat_s;
    logic            fire_s;

    // Count seen by decode this cycle: same-cycle retirements and kills already subtracted.
    function automatic int eff_f(input logic [CW-1:0] c, input logic [4:0] r,
                                 input logic wv, input logic [4:0] wrd,
                                 input logic kv, input logic [4:0] krd);
        int e;
        e = int'(c);
        if (r == 5'd0) begin
            e = 0;
        end else begin
            if (wv && (wrd == r)) e = e - 1;
            if (kv && (krd == r)) e = e - 1;
        end
        return e;
    endfunction

    // Hazard detection and issue handshake, combinational from current counts.
    always_comb begin
        haz_s = (sb.dec_use_rs1 && (sb.dec_rs1 != 5'd0) &&
                 (eff_f(cnt_r[sb.dec_rs1], sb.dec_rs1, sb.wb_valid, sb.wb_rd,
                        sb.kill_valid, sb.kill_rd) != 0)) ||
                (sb.dec_use_rs2 && (sb.dec_rs2 != 5'd0) &&
                 (eff_f(cnt_r[sb.dec_rs2], sb.dec_rs2, sb.wb_valid, sb.wb_rd,
                        sb.kill_valid, sb.kill_rd) != 0));
        sat_s = sb.dec_wen && (sb.dec_rd != 5'd0) &&
                (eff_f(cnt_r[sb.dec_rd], sb.dec_rd, sb.wb_valid, sb.wb_rd,
                       sb.kill_valid, sb.kill_rd) == CMAX);
        fire_s = sb.dec_valid && !haz_s && !sat_s && sb.issue_ready;
    end

    assign sb.stall        = sb.dec_valid && (haz_s || sat_s);
    assign sb.issue_fire   = fire_s;
    assign sb.busy         = busy_r;
    assign sb.pending_mask = mask_r;
    assign sb.err          = err_r;

    // Next counter values; an underflow clamps at zero and flags the error.
    always_comb begin
        int up_v;
        int dn_v;
        up_v         = 0;
        dn_v         = 0;
        under_s      = 1'b0;
        mask_nxt_s   = '0;
        cnt_nxt_s[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            up_v = int'(cnt_r[r]) +
                   ((fire_s && sb.dec_wen && (sb.dec_rd == 5'(r))) ? 1 : 0);
            dn_v = ((sb.wb_valid && (sb.wb_rd == 5'(r))) ? 1 : 0) +
                   ((sb.kill_valid && (sb.kill_rd == 5'(r))) ? 1 : 0);
            if (up_v < dn_v) begin
                cnt_nxt_s[r] = '0;
                under_s      = 1'b1;
            end else begin
                cnt_nxt_s[r] = CW'(up_v - dn_v);
            end
            mask_nxt_s[r] = (cnt_nxt_s[r] != '0);
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) cnt_r[r] <= '0;
            mask_r <= '0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_r[r] <= cnt_nxt_s[r];
            mask_r <= mask_nxt_s;
            busy_r <= (mask_nxt_s != '0);
            err_r  <= err_r | under_s;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random
// traffic against a counting reference model.
module tb_issue_scoreboard;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   mc [32];
    bit   merr;
    bit   exp_stall;
    bit   exp_fire;

    issue_scoreboard_if #(.NREG(32)) sbif ();

    issue_scoreboard #(.NREG(32), .CW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int effm(input int r);
        int e;
        if (r == 0) return 0;
        e = mc[r];
        if (sbif.wb_valid && int'(sbif.wb_rd) == r) e--;
        if (sbif.kill_valid && int'(sbif.kill_rd) == r) e--;
        return e;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        for (int r = 1; r < 32; r++) m[r] = (mc[r] != 0);
        return m;
    endfunction

    task automatic model_comb();
        bit haz;
        bit sat;
        haz = (sbif.dec_use_rs1 && sbif.dec_rs1 != 5'd0 && effm(int'(sbif.dec_rs1)) != 0) ||
              (sbif.dec_use_rs2 && sbif.dec_rs2 != 5'd0 && effm(int'(sbif.dec_rs2)) != 0);
        sat = sbif.dec_wen && sbif.dec_rd != 5'd0 && effm(int'(sbif.dec_rd)) == 3;
        exp_stall = sbif.dec_valid && (haz || sat);
        exp_fire  = sbif.dec_valid && !haz && !sat && sbif.issue_ready;
    endtask

    task automatic model_edge();
        int d;
        model_comb();
        for (int r = 1; r < 32; r++) begin
            d = mc[r];
            if (exp_fire && sbif.dec_wen && int'(sbif.dec_rd) == r) d++;
            if (sbif.wb_valid && int'(sbif.wb_rd) == r) d--;
            if (sbif.kill_valid && int'(sbif.kill_rd) == r) d--;
            if (d < 0) begin
                mc[r] = 0;
                merr  = 1'b1;
            end else begin
                mc[r] = d;
            end
        end
    endtask

    task automatic set_idle();
        sbif.dec_valid = 1'b0; sbif.dec_rs1 = 5'd0; sbif.dec_rs2 = 5'd0;
        sbif.dec_use_rs1 = 1'b0; sbif.dec_use_rs2 = 1'b0;
        sbif.dec_rd = 5'd0; sbif.dec_wen = 1'b0; sbif.issue_ready = 1'b1;
        sbif.wb_valid = 1'b0; sbif.wb_rd = 5'd0; sbif.kill_valid = 1'b0; sbif.kill_rd = 5'd0;
    endtask

    task automatic set_dec(input bit u1, input int rs1, input bit u2, input int rs2,
                           input bit wen, input int rd);
        sbif.dec_valid = 1'b1;
        sbif.dec_use_rs1 = u1; sbif.dec_rs1 = 5'(rs1);
        sbif.dec_use_rs2 = u2; sbif.dec_rs2 = 5'(rs2);
        sbif.dec_wen = wen; sbif.dec_rd = 5'(rd);
    endtask

    // One clock: compare against the model before the edge, then advance the model.
    task automatic cycle(input string tag);
        #1;
        model_comb();
        check_eq({tag, "_stall"}, 32'(sbif.stall), 32'(exp_stall));
        check_eq({tag, "_fire"}, 32'(sbif.issue_fire), 32'(exp_fire));
        check_eq({tag, "_mask"}, sbif.pending_mask, model_mask());
        check_eq({tag, "_busy"}, 32'(sbif.busy), 32'(model_mask() != 32'd0));
        check_eq({tag, "_err"}, 32'(sbif.err), 32'(merr));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        int guard;
        int pick;
        guard = 0;
        while (model_mask() != 32'd0 && guard < 200) begin
            set_idle();
            pick = 0;
            for (int r = 31; r >= 1; r--) if (mc[r] != 0) pick = r;
            sbif.wb_valid = 1'b1; sbif.wb_rd = 5'(pick);
            cycle("drain");
            guard++;
        end
        set_idle();
        if (guard >= 200) check_eq("drain_bound", 32'(sbif.busy), 32'd0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mc[r] = 0;
        merr = 1'b0;
    endtask

    initial begin
        int a;
        int b;
        clk = 1'b0; reset = 1'b0; n_checks = 0; n_pass = 0;
        model_reset();
        set_idle();
        #1;
        check_eq("rst_stall", 32'(sbif.stall), 32'd0);
        check_eq("rst_fire", 32'(sbif.issue_fire), 32'd0);
        check_eq("rst_busy", 32'(sbif.busy), 32'd0);
        check_eq("rst_mask", sbif.pending_mask, 32'd0);
        check_eq("rst_err", 32'(sbif.err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back independent ADDI x1, ADDI x2.
        set_dec(1'b1, 0, 1'b0, 0, 1'b1, 1); #1;
        check_eq("addi1_fire", 32'(sbif.issue_fire), 32'd1);
        cycle("addi1");
        set_dec(1'b1, 0, 1'b0, 0, 1'b1, 2); #1;
        check_eq("addi2_fire", 32'(sbif.issue_fire), 32'd1);
        check_eq("addi2_stall", 32'(sbif.stall), 32'd0);
        cycle("addi2");
        check_eq("addi_mask", sbif.pending_mask, 32'h6);
        drain();

        // RAW on x3, released by same-cycle writeback.
        set_dec(1'b1, 0, 1'b1, 0, 1'b1, 3); cycle("raw_prod");
        set_dec(1'b1, 3, 1'b1, 5, 1'b1, 4); #1;
        check_eq("raw_stall", 32'(sbif.stall), 32'd1);
        cycle("raw_w0");
        cycle("raw_w1");
        sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd3; #1;
        check_eq("raw_rel_stall", 32'(sbif.stall), 32'd0);
        check_eq("raw_rel_fire", 32'(sbif.issue_fire), 32'd1);
        cycle("raw_rel");
        set_idle();
        check_eq("raw_x3_clear", 32'(sbif.pending_mask[3]), 32'd0);
        drain();

        // Operand-use gating around pending x6.
        set_dec(1'b1, 0, 1'b0, 0, 1'b1, 6); cycle("x6_prod");
        set_dec(1'b0, 6, 1'b0, 6, 1'b1, 7); #1;
        check_eq("lui_stall", 32'(sbif.stall), 32'd0);
        cycle("lui");
        set_dec(1'b0, 6, 1'b0, 6, 1'b1, 1); cycle("jal");
        set_dec(1'b1, 0, 1'b1, 6, 1'b0, 0); #1;
        check_eq("sd_stall", 32'(sbif.stall), 32'd1);
        cycle("sd");
        drain();

        // Saturation on x8.
        for (int i = 0; i < 3; i++) begin
            set_dec(1'b1, 0, 1'b0, 0, 1'b1, 8); cycle("sat_fill");
        end
        set_dec(1'b1, 0, 1'b0, 0, 1'b1, 8); #1;
        check_eq("sat_stall", 32'(sbif.stall), 32'd1);
        check_eq("sat_nofire", 32'(sbif.issue_fire), 32'd0);
        cycle("sat_full");
        sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd8; #1;
        check_eq("sat_wb_fire", 32'(sbif.issue_fire), 32'd1);
        cycle("sat_wb");
        sbif.wb_valid = 1'b0; #1;
        check_eq("sat_still3", 32'(sbif.stall), 32'd1);
        cycle("sat_still");
        drain();

        // Writeback plus kill on x9, then an underflow.
        set_dec(1'b1, 0, 1'b0, 0, 1'b1, 9); cycle("x9_a");
        cycle("x9_b");
        set_idle();
        sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd9;
        sbif.kill_valid = 1'b1; sbif.kill_rd = 5'd9;
        cycle("wbkill");
        set_idle();
        check_eq("wbkill_mask", sbif.pending_mask, 32'd0);
        check_eq("wbkill_err", 32'(sbif.err), 32'd0);
        sbif.wb_valid = 1'b1; sbif.wb_rd = 5'd9;
        cycle("under");
        set_idle();
        check_eq("under_err", 32'(sbif.err), 32'd1);
        check_eq("under_mask", sbif.pending_mask, 32'd0);

        // Async reset while stalled on x10.
        set_dec(1'b1, 0, 1'b0, 0, 1'b1, 10); cycle("x10");
        set_dec(1'b1, 10, 1'b0, 0, 1'b1, 11); #1;
        check_eq("ar_stall_pre", 32'(sbif.stall), 32'd1);
        #2; reset = 1'b0; #1;
        check_eq("ar_stall", 32'(sbif.stall), 32'd0);
        check_eq("ar_busy", 32'(sbif.busy), 32'd0);
        check_eq("ar_mask", sbif.pending_mask, 32'd0);
        check_eq("ar_err", 32'(sbif.err), 32'd0);
        model_reset();
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Random traffic; retirements and kills only target pending registers.
        for (int n = 0; n < 600; n++) begin
            set_idle();
            if ($urandom_range(0, 9) < 8) begin
                set_dec(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), $urandom_range(0, 7));
            end
            sbif.issue_ready = ($urandom_range(0, 3) != 0);
            a = $urandom_range(1, 7);
            b = $urandom_range(1, 7);
            if (mc[a] != 0 && $urandom_range(0, 9) < 5) begin
                sbif.wb_valid = 1'b1; sbif.wb_rd = 5'(a);
            end
            if (mc[b] != 0 && $urandom_range(0, 9) < 2 && (b != a || mc[b] >= 2 || !sbif.wb_valid)) begin
                sbif.kill_valid = 1'b1; sbif.kill_rd = 5'(b);
            end
            cycle("rnd");
        end
        drain();
        check_eq("rnd_err", 32'(sbif.err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Decode-stage issue controller for the in-order RISC-V pipeline. It tracks the in-flight register writes of every instruction issued past decode, using a small pending counter per architectural register. It holds the decode stage (stall) while an operand that feeds the srca/srcb selection is still being produced. It releases the stall when the producer retires at writeback or is killed by a flush.

## Interface
Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CW, 2, pending-counter width; the maximum number of in-flight writes per register is 2^CW-1 (3).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1, dec_rs2  in  5  source register indices.
- dec_use_rs1, dec_use_rs2  in  1  the operand is read from the register file. Per op class:
  - rs1 and rs2: R-type ALU, BEQ, SD.
  - rs1 only: I-type ALU, LD, JALR.
  - none: LUI, AUIPC, JAL.
- dec_rd  in  5  destination index.
- dec_wen  in  1  the instruction writes rd.
- issue_ready  in  1  execute stage can accept.
- issue_fire  out  1  the instruction leaves decode this cycle.
- stall  out  1  decode must hold its instruction.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_rd  in  5  index of that write.
- kill_valid  in  1  a flushed in-flight instruction with a pending write is discarded this cycle.
- kill_rd  in  5  index of that write.
- busy  out  1  at least one counter is nonzero.
- pending_mask  out  NREG  bit i set when cnt[i] != 0; bit 0 is always 0.
- err  out  1  sticky; set on counter underflow.

## Operation
- State: cnt[1..NREG-1] (CW bits each) and err. There is no separate FSM; each register follows IDLE (cnt==0) -> PENDING (cnt>0) -> IDLE.
- Hit signals:
  - wb_hit(r) = wb_valid && wb_rd==r && r!=0
  - kill_hit(r) = kill_valid && kill_rd==r && r!=0
- Effective count: eff(r) = cnt[r] - wb_hit(r) - kill_hit(r). A same-cycle retirement therefore clears a hazard; the register file is write-before-read.
- Read hazard: haz = (dec_use_rs1 && dec_rs1!=0 && eff(dec_rs1)!=0) || (dec_use_rs2 && dec_rs2!=0 && eff(dec_rs2)!=0).
- Structural hazard: sat = dec_wen && dec_rd!=0 && eff(dec_rd)==2^CW-1.
- stall = dec_valid && (haz || sat). A hazard must not wait on issue_ready.
- issue_fire = dec_valid && !haz && !sat && issue_ready.
- Counter update per register r each edge: cnt[r] <= cnt[r] + inc(r) - wb_hit(r) - kill_hit(r), where inc(r) = issue_fire && dec_wen && dec_rd==r && r!=0.
- Simultaneous events:
  - issue + writeback on the same r leaves cnt unchanged.
  - writeback + kill on the same r decrements by 2.
  - All three events on the same r decrement by 1.
- Underflow: when cnt[r] + inc(r) < wb_hit(r) + kill_hit(r), the counter stays at 0 and err is set. err stays set until reset.
- WAW is allowed: multiple writes to the same rd simply raise the counter.
- rd==0 or rs==0 never stalls and never changes state.

## Timing
- Reset (async assert, sync to clk on deassert): all cnt = 0, err = 0. Outputs: stall=0, issue_fire=0, busy=0, pending_mask=0, err=0.
- stall and issue_fire are combinational from the current cnt and same-cycle inputs, with zero latency.
- cnt, busy, pending_mask and err reflect an event on the edge after it occurs.
- Issue-to-visibility latency is 1 cycle: a dependent instruction in the very next decode cycle sees cnt!=0.
- Reset asserted mid-operation discards all pending state immediately. The pipeline is reset at the same time, so no orphan writebacks arrive.

## Test plan
- Reset then back-to-back independent ops: ADDI x1 then ADDI x2 with dec_valid=1 and issue_ready=1 every cycle -> issue_fire=1 both cycles, stall=0; pending_mask=0x6 after the second edge.
- RAW: ADD x3 issues, next cycle ADD x4,x3,x5 -> stall=1 until the cycle with wb_valid=1, wb_rd=3. In that cycle stall=0 and issue_fire=1, and afterwards cnt[3]=0.
- Operand-use gating: x6 pending, decode LUI x7 (no sources) and JAL -> no stall. A following SD reading rs2=x6 -> stall=1.
- Saturation: three writes to x8 issued with no writeback -> cnt[8]=3. A fourth write to x8 gives stall=1 and issue_fire=0. Asserting wb_rd=8 in that cycle gives issue_fire=1 and cnt[8] stays 3.
- Simultaneous events plus kill: cnt[9]=2, then in one cycle wb_rd=9 and kill_rd=9 -> cnt[9]=0 and err=0. A further wb_rd=9 -> err=1, cnt[9]=0.
- Async reset mid-stall: with x10 pending and stall=1, pull reset low between edges -> stall, busy and pending_mask drop to 0 immediately.
